qspi_flash_controller: RTL and testbench

Read-only quad-SPI NOR flash controller that serves cartridge ROM bytes to the Atari 2600 system core. It issues Fast Read Quad I/O (0xEB) transactions and streams sequential words to an internal requester. It sits between the ROM fetch/caching logic of the top level and the QSPI PMOD pins on the bidirectional I/O bus.

---
 rtl/qspi_flash_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_qspi_flash_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_controller.sv
`timescale 1ns/1ps
// Read-only quad-SPI NOR flash streamer: issues Fast Read Quad I/O (0xEB) and assembles bytes into words.
// Define QSPI_INPUT_REG_EN to register spi_data_in for one clk before nibble capture.
module qspi_flash_controller #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ADDR_BITS        = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      spi_data_in,
    output logic [3:0]                      spi_data_out,
    output logic [3:0]                      spi_data_oe,
    output logic                            spi_select,
    output logic                            spi_clk_out,
    input  logic [ADDR_BITS-1:0]            addr_in,
    input  logic                            start_read,
    input  logic                            stall_read,
    input  logic                            stop_read,
    output logic [8*DATA_WIDTH_BYTES-1:0]   data_out,
    output logic                            data_ready,
    output logic                            busy
);

    localparam int W         = 8 * DATA_WIDTH_BYTES;
    localparam int SH_W      = ADDR_BITS + 8;
    localparam int ADDR_NIBS = ADDR_BITS / 4;
    localparam int CNT_W     = $clog2(ADDR_NIBS + 8);
    localparam int BYTE_W    = (DATA_WIDTH_BYTES > 1) ? $clog2(DATA_WIDTH_BYTES) : 1;
    localparam logic [7:0]        FAST_READ_QUAD = 8'hEB;
    localparam logic [BYTE_W-1:0] LAST_BYTE      = BYTE_W'(DATA_WIDTH_BYTES - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, STALL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic               sck_q, sck_d;
    logic               sel_q, sel_d;
    logic [3:0]         oe_q, oe_d;
    logic [3:0]         sdo_q, sdo_d;
    logic               busy_q, busy_d;
    logic [W-1:0]       data_q, data_d;
    logic               ready_q, ready_d;
    logic [3:0]         hi_q, hi_d;
    logic               want_hi_q, want_hi_d;
    logic [BYTE_W-1:0]  byte_idx_q, byte_idx_d;
    logic [W-1:0]       acc_q, acc_d;

    logic               live;
    logic               fall;
    logic               cap_valid;
    logic [3:0]         cap_nib;

`ifdef QSPI_INPUT_REG_EN
    logic [3:0]         spi_in_q;
    logic               cap_pend_q, cap_pend_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        sck_d      = sck_q;
        sel_d      = sel_q;
        oe_d       = oe_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        data_d     = data_q;
        ready_d    = ready_q;
        hi_d       = hi_q;
        want_hi_d  = want_hi_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;

        unique case (state_q)
            IDLE: begin
                if (start_read) begin
                    state_d    = CMD;
                    busy_d     = 1'b1;
                    sel_d      = 1'b0;
                    sck_d      = 1'b0;
                    oe_d       = 4'b0001;
                    sdo_d      = {3'b000, FAST_READ_QUAD[7]};
                    sh_d       = {FAST_READ_QUAD[6:0], addr_in, 1'b0};
                    cnt_d      = CNT_W'(7);
                    want_hi_d  = 1'b1;
                    byte_idx_d = '0;
                    ready_d    = 1'b0;
                end
            end
            CMD, ADDR, MODE, DUMMY: begin
                sck_d = ~sck_q;
                // All output changes happen on the SCK falling edge.
                if (sck_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (state_q == CMD) begin
                            sdo_d = {3'b000, sh_q[SH_W-1]};
                            sh_d  = sh_q << 1;
                        end else if (state_q == ADDR) begin
                            sdo_d = sh_q[SH_W-1 -: 4];
                            sh_d  = sh_q << 4;
                        end
                    end else begin
                        unique case (state_q)
                            CMD: begin
                                state_d = ADDR;
                                oe_d    = 4'b1111;
                                sdo_d   = sh_q[SH_W-1 -: 4];
                                sh_d    = sh_q << 4;
                                cnt_d   = CNT_W'(ADDR_NIBS - 1);
                            end
                            ADDR: begin
                                state_d = MODE;
                                sdo_d   = 4'hF;
                                cnt_d   = CNT_W'(1);
                            end
                            MODE: begin
                                state_d = DUMMY;
                                oe_d    = 4'b0000;
                                sdo_d   = 4'h0;
                                cnt_d   = CNT_W'(3);
                            end
                            default: state_d = DATA;
                        endcase
                    end
                end
            end
            DATA: begin
                if (ready_q && stall_read) begin
                    state_d = STALL;
                    sck_d   = 1'b0;
                end else begin
                    sck_d   = ~sck_q;
                    ready_d = 1'b0;
                end
            end
            STALL: begin
                if (!stall_read) begin
                    state_d = DATA;
                    sck_d   = 1'b1;
                    ready_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (busy_q && stop_read) begin
            state_d = IDLE;
            sel_d   = 1'b1;
            sck_d   = 1'b0;
            oe_d    = 4'b0000;
            sdo_d   = 4'h0;
            busy_d  = 1'b0;
            ready_d = 1'b0;
        end

        live = (state_d == DATA) || (state_d == STALL);
        fall = live && (state_q == DATA || state_q == STALL) && sck_q && !sck_d;

`ifdef QSPI_INPUT_REG_EN
        // The pin value registered at the fall is consumed one edge later, even inside STALL.
        cap_pend_d = fall;
        cap_valid  = cap_pend_q && live;
        cap_nib    = spi_in_q;
`else
        cap_valid  = fall;
        cap_nib    = spi_data_in;
`endif

        if (cap_valid) begin
            if (want_hi_q) begin
                hi_d      = cap_nib;
                want_hi_d = 1'b0;
            end else begin
                want_hi_d = 1'b1;
                acc_d[{byte_idx_q, 3'b000} +: 8] = {hi_q, cap_nib};
                if (byte_idx_q == LAST_BYTE) begin
                    data_d     = acc_d;
                    ready_d    = 1'b1;
                    byte_idx_d = '0;
                end else begin
                    byte_idx_d = byte_idx_q + BYTE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            sck_q      <= 1'b0;
            sel_q      <= 1'b1;
            oe_q       <= 4'b0000;
            sdo_q      <= 4'h0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            hi_q       <= 4'h0;
            want_hi_q  <= 1'b1;
            byte_idx_q <= '0;
            acc_q      <= '0;
`ifdef QSPI_INPUT_REG_EN
            spi_in_q   <= 4'h0;
            cap_pend_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates make every flop see the pre-edge value of its peers.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            sck_q      <= sck_d;
            sel_q      <= sel_d;
            oe_q       <= oe_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            hi_q       <= hi_d;
            want_hi_q  <= want_hi_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
`ifdef QSPI_INPUT_REG_EN
            spi_in_q   <= spi_data_in;
            cap_pend_q <= cap_pend_d;
`endif
        end
    end

    assign spi_data_out = sdo_q;
    assign spi_data_oe  = oe_q;
    assign spi_select   = sel_q;
    assign spi_clk_out  = sck_q;
    assign data_out     = data_q;
    assign data_ready   = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_qspi_flash_controller.sv
`timescale 1ns/1ps
// Randomized self-checking bench for qspi_flash_controller with a behavioural 0xEB flash model and word scoreboard.
module tb_qspi_flash_controller;

    localparam int NB = 1;
    localparam int AB = 24;
    localparam int W  = 8 * NB;
`ifdef QSPI_INPUT_REG_EN
    localparam int FIRST_LAT = 45;
`else
    localparam int FIRST_LAT = 44;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    spi_data_in;
    logic [3:0]    spi_data_out;
    logic [3:0]    spi_data_oe;
    logic          spi_select;
    logic          spi_clk_out;
    logic [AB-1:0] addr_in;
    logic          start_read;
    logic          stall_read;
    logic          stop_read;
    logic [W-1:0]  data_out;
    logic          data_ready;
    logic          busy;

    always #5 clk = ~clk;

    qspi_flash_controller #(.DATA_WIDTH_BYTES(NB), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .spi_select   (spi_select),
        .spi_clk_out  (spi_clk_out),
        .addr_in      (addr_in),
        .start_read   (start_read),
        .stall_read   (stall_read),
        .stop_read    (stop_read),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flash contents: address low byte plus 0xA5 unless overridden.
    logic [7:0] rom_ovr [logic [23:0]];

    function automatic logic [7:0] rom(input logic [23:0] a);
        if (rom_ovr.exists(a)) return rom_ovr[a];
        return 8'(a[7:0] + 8'hA5);
    endfunction

    // Behavioural flash: decodes the 0xEB frame from SCK rising edges and serves nibbles.
    int         fl_rise = 0;
    logic [7:0] fl_cmd;
    logic [23:0] fl_addr;
    logic [7:0] fl_mode;
    logic [3:0] fl_drive = 4'h0;
    logic [23:0] exp_addr;

    assign spi_data_in = fl_drive;

    always @(posedge spi_select) fl_rise = 0;

    always @(posedge spi_clk_out) begin
        if (!spi_select) begin
            fl_rise++;
            if (fl_rise <= 8) begin
                fl_cmd = {fl_cmd[6:0], spi_data_out[0]};
                if (fl_rise == 8) begin
                    check("flash_cmd", fl_cmd, 8'hEB);
                    check("oe_cmd", spi_data_oe, 4'b0001);
                end
            end else if (fl_rise <= 14) begin
                fl_addr = {fl_addr[19:0], spi_data_out};
                if (fl_rise == 14) begin
                    check("flash_addr", fl_addr, exp_addr);
                    check("oe_addr", spi_data_oe, 4'b1111);
                end
            end else if (fl_rise <= 16) begin
                fl_mode = {fl_mode[3:0], spi_data_out};
                if (fl_rise == 16) check("flash_mode", fl_mode, 8'hFF);
            end else if (fl_rise <= 20) begin
                if (fl_rise == 20) check("oe_dummy", spi_data_oe, 4'b0000);
            end else begin
                automatic int k = fl_rise - 21;
                automatic logic [7:0] b = rom(24'(fl_addr + 24'(k / 2)));
                #1 fl_drive = (k % 2 == 0) ? b[7:4] : b[3:0];
            end
        end
    end

    // Scoreboard: every rising data_ready must carry the next sequential word.
    int   cyc = 0;
    int   e0 = 0;
    int   word_idx = 0;
    int   rise_q[$];
    logic dr_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            dr_prev = 1'b0;
        end else begin
            if (data_ready && !dr_prev) begin
                automatic logic [W-1:0] w;
                for (int j = 0; j < NB; j++)
                    w[j*8 +: 8] = rom(24'(exp_addr + 24'(word_idx * NB + j)));
                check("word", data_out, w);
                word_idx++;
                rise_q.push_back(cyc);
            end
            dr_prev = data_ready;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] a);
        addr_in    = a;
        start_read = 1'b1;
        exp_addr   = a;
        word_idx   = 0;
        rise_q.delete();
        @(posedge clk);
        #1;
        e0         = cyc;
        start_read = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int c = 0;
        while (word_idx < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 64'(word_idx >= n), 64'd1);
    endtask

    task automatic stop();
        stop_read = 1'b1;
        tick();
        stop_read = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},  spi_select, 1'b1);
        check({tag, "_sck"},  spi_clk_out, 1'b0);
        check({tag, "_oe"},   spi_data_oe, 4'h0);
        check({tag, "_sdo"},  spi_data_out, 4'h0);
        check({tag, "_data"}, data_out, '0);
        check({tag, "_rdy"},  data_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        reset      = 1'b1;
        addr_in    = '0;
        start_read = 1'b0;
        stall_read = 1'b0;
        stop_read  = 1'b0;
        rom_ovr[24'h200000] = 8'h12;
        rom_ovr[24'h200001] = 8'h34;
        rom_ovr[24'h200002] = 8'h56;
        tick(3);
        reset = 1'b0;
        check_reset_values("reset");

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (spi_clk_out !== 1'b0 || spi_select !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);

        // First word latency and stop retaining data_out.
        start(24'h100000);
        check("busy_start", busy, 1'b1);
        check("sel_start", spi_select, 1'b0);
        check("sdo_bit7", spi_data_out, 4'h1);
        wait_words(1, 100, "first_word_timeout");
        if (rise_q.size() > 0) check("first_latency", rise_q[0] - e0, FIRST_LAT);
        stop();
        check("stop_busy", busy, 1'b0);
        check("stop_keep_data", data_out, 8'hA5);

        // Unstalled stream spacing.
        start(24'h200000);
        wait_words(3, 200, "stream_timeout");
        if (rise_q.size() >= 3) begin
            check("spacing_1", rise_q[1] - rise_q[0], 4 * NB);
            check("spacing_2", rise_q[2] - rise_q[1], 4 * NB);
        end
        stop();

        // Stall for 20 cycles at the first word.
        stall_read = 1'b1;
        start(24'h100000);
        wait_words(1, 100, "stall_first_timeout");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spi_clk_out !== 1'b0 || data_ready !== 1'b1 || data_out !== 8'hA5 || spi_select !== 1'b0) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_no_new_word", word_idx, 1);
        stall_read = 1'b0;
        wait_words(3, 100, "stall_release_timeout");
        stop();

        // Stop during ADDR, then a full fresh transaction.
        start(24'h345678);
        tick(20);
        stop();
        check("abort_sel", spi_select, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_oe", spi_data_oe, 4'h0);
        check("abort_sck", spi_clk_out, 1'b0);
        tick();
        start(24'h345678);
        wait_words(2, 150, "restart_timeout");
        stop();

        // start_read while busy must not relatch the address.
        start(24'h0ABCDE);
        tick(10);
        addr_in    = 24'h111111;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        check("busy_ignore_start", busy, 1'b1);
        wait_words(2, 150, "busy_start_timeout");

        // stop and start together: stop wins.
        addr_in    = 24'h222222;
        start_read = 1'b1;
        stop_read  = 1'b1;
        tick();
        start_read = 1'b0;
        stop_read  = 1'b0;
        check("stop_wins_busy", busy, 1'b0);
        tick();
        check("stop_wins_idle", busy, 1'b0);

        // stop while idle.
        stop();
        check("idle_stop_sel", spi_select, 1'b1);

        // reset during DATA.
        start(24'h00F0F0);
        wait_words(1, 100, "pre_reset_timeout");
        tick(3);
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset");
        reset = 1'b0;
        tick();

        // Randomized transactions with random stalls.
        for (int t = 0; t < 10; t++) begin
            int nw;
            int c;
            nw = $urandom_range(2, 6);
            start(24'($urandom));
            c = 0;
            while (word_idx < nw && c < 600) begin
                stall_read = ($urandom_range(0, 2) == 0);
                tick();
                c++;
            end
            check("rand_words", 64'(word_idx >= nw), 64'd1);
            stall_read = 1'b0;
            stop();
            check("rand_stop_busy", busy, 1'b0);
            tick($urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
